// File: rtl/serial_link_bist.sv
// serial_link_bist: write/read-compare self-test engine that exercises each serial link in turn
// and reports per-link pass, a saturating error count and the first failing address/link.
module serial_link_bist #(
  parameter int NumLinks       = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxWords       = 16,
  parameter int MaxOutstanding = 4,
  localparam int CntW  = $clog2(MaxWords + 1),
  localparam int LinkW = NumLinks > 1 ? $clog2(NumLinks) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic                 pattern_i,
  input  logic [DataWidth-1:0] seed_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntW-1:0]      num_words_i,
  input  logic [NumLinks-1:0]  train_done_i,
  output logic [LinkW-1:0]     link_sel_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NumLinks-1:0]  pass_o,
  output logic [15:0]          err_cnt_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  output logic [LinkW-1:0]     first_err_link_o
);
  localparam int OW = $clog2(MaxOutstanding + 1);
  typedef enum logic [2:0] {IDLE, WAIT_TRAIN, WRITE, READ, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [1:0]           mode;
  logic                 pat;
  logic [DataWidth-1:0] seed;
  logic [AddrWidth-1:0] base;
  logic [CntW-1:0]      n, issued, rcvd, rcvd_n;
  logic [LinkW-1:0]     link;
  logic [OW-1:0]        outst, os_n;
  logic                 lost, trained, free, fire, rsp, mism, loss, can_issue;

  function automatic logic [DataWidth-1:0] pat_f(input logic p, input logic [DataWidth-1:0] s,
                                                 input logic [CntW-1:0] i);
    return p ? s ^ (DataWidth'(1) << (32'(i) % DataWidth)) : s + DataWidth'(i);
  endfunction

  always_comb begin
    trained   = train_done_i[link];
    free      = !req_o || gnt_i;
    fire      = req_o && gnt_i;
    rsp       = rvalid_i && outst != '0;
    os_n      = outst + OW'(fire && !we_o) - OW'(rsp);
    rcvd_n    = rcvd + CntW'(rsp);
    mism      = rsp && rdata_i != pat_f(pat, seed, rcvd);
    loss      = lost || !trained;
    can_issue = free && !loss && issued < n &&
                (state == WRITE || (state == READ && os_n < OW'(MaxOutstanding)));
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = start_i ? WAIT_TRAIN : IDLE;
      WAIT_TRAIN: if (trained) state_n = mode == 2'd2 ? READ : WRITE;
      WRITE:      if (!trained) state_n = NEXT;
                  else if (free && issued == n) state_n = mode == 2'd1 ? NEXT : READ;
      READ:       if (os_n == '0 && (loss || rcvd_n == n)) state_n = NEXT;
      NEXT:       state_n = link == LinkW'(NumLinks - 1) ? DONE : WAIT_TRAIN;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode             <= '0;
      pat              <= 1'b0;
      seed             <= '0;
      base             <= '0;
      n                <= '0;
      issued           <= '0;
      rcvd             <= '0;
      link             <= '0;
      outst            <= '0;
      lost             <= 1'b0;
      req_o            <= 1'b0;
      we_o             <= 1'b0;
      addr_o           <= '0;
      wdata_o          <= '0;
      pass_o           <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      first_err_link_o <= '0;
    end else begin
      outst <= os_n;
      rcvd  <= rcvd_n;
      if (state == IDLE && start_i) begin
        mode             <= mode_i;
        pat              <= pattern_i;
        seed             <= seed_i;
        base             <= base_addr_i;
        n                <= num_words_i == '0 ? CntW'(1) :
                            num_words_i > CntW'(MaxWords) ? CntW'(MaxWords) : num_words_i;
        link             <= '0;
        pass_o           <= NumLinks'(1);
        err_cnt_o        <= '0;
        first_err_addr_o <= '0;
        first_err_link_o <= '0;
      end
      if (state == WAIT_TRAIN) begin
        issued <= '0;
        rcvd   <= '0;
        lost   <= 1'b0;
      end
      if (state == NEXT && state_n == WAIT_TRAIN) begin
        link                     <= link + LinkW'(1);
        pass_o[link + LinkW'(1)] <= 1'b1;
      end
      if ((state == WRITE || state == READ) && !trained) begin
        lost         <= 1'b1;
        pass_o[link] <= 1'b0;
      end
      if (mism) begin
        pass_o[link] <= 1'b0;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
        if (err_cnt_o == '0) begin
          first_err_addr_o <= base + AddrWidth'(rcvd);
          first_err_link_o <= link;
        end
      end
      // Request outputs only change once the current beat is granted (or abandoned on training loss).
      if (can_issue) begin
        req_o   <= 1'b1;
        we_o    <= state == WRITE;
        addr_o  <= base + AddrWidth'(issued);
        wdata_o <= pat_f(pat, seed, issued);
        issued  <= issued + CntW'(1);
      end else if (free || loss) begin
        req_o <= 1'b0;
      end
      if (state == WRITE && state_n == READ) issued <= '0;
    end
  end

  assign link_sel_o = link;
  assign busy_o     = state inside {WAIT_TRAIN, WRITE, READ, NEXT};
  assign done_o     = state == DONE;
endmodule

// File: tb/tb_serial_link_bist.sv
// tb_serial_link_bist: scoreboard bench for serial_link_bist with a two-link memory model,
// configurable read latency, grant stalls, read corruption and training loss.
module tb_serial_link_bist;
  logic        clk = 1'b0;
  logic        rst_ni, start_i, pattern_i, gnt_i, rvalid_i;
  logic [1:0]  mode_i, train_done_i, pass_o;
  logic [63:0] seed_i, rdata_i, wdata_o;
  logic [31:0] base_addr_i, addr_o, first_err_addr_o;
  logic [4:0]  num_words_i;
  logic        link_sel_o, first_err_link_o, req_o, we_o, busy_o, done_o;
  logic [15:0] err_cnt_o;

  serial_link_bist #(.NumLinks(2), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i), .pattern_i(pattern_i),
    .seed_i(seed_i), .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .train_done_i(train_done_i), .link_sel_o(link_sel_o), .req_o(req_o), .gnt_i(gnt_i),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .first_err_link_o(first_err_link_o)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] Seed = 64'h1234_5678_face_feed;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_wa[$], exp_ra[$];
  logic [63:0] exp_wd[$], rsp_dat[$];
  int          rsp_due[$];
  logic [63:0] mem[logic [31:0]];
  int          cyc = 0, lat = 1, gnt_mode = 0, drop_at = 0;
  int          os_model = 0, os_peak = 0, wr_fires = 0, rd_fires = 0, done_cnt = 0;
  logic        corrupt_en = 1'b0, drop_arm = 1'b0, hold0 = 1'b0, spur_req = 1'b0;
  logic [31:0] corrupt_addr = '0, prev_addr = '0;
  logic        prev_pend = 1'b0, prev_we = 1'b0;
  logic [63:0] prev_wd = '0, rd_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input logic p, input logic [63:0] s, input int i);
    return p ? s ^ (64'd1 << (i % 64)) : s + 64'(i);
  endfunction

  task automatic push_link(input logic p, input logic [63:0] s, input logic [31:0] b,
                           input int nwr, input int nrd);
    for (int i = 0; i < nwr; i++) begin
      exp_wa.push_back(b + 32'(i));
      exp_wd.push_back(pexp(p, s, i));
    end
    for (int i = 0; i < nrd; i++) exp_ra.push_back(b + 32'(i));
  endtask

  task automatic run(input logic [1:0] m, input logic p, input logic [63:0] s,
                     input logic [31:0] b, input logic [4:0] nw);
    @(posedge clk); #2;
    mode_i = m; pattern_i = p; seed_i = s; base_addr_i = b; num_words_i = nw;
    start_i = 1'b1; done_cnt = 0; wr_fires = 0; rd_fires = 0; os_peak = 0;
    @(posedge clk); #2;
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1);
  endtask

  task automatic finish_run(input logic [1:0] pass, input logic [15:0] err,
                            input logic [31:0] fa, input logic fl);
    int k = 0;
    while (!done_o && k < 2000) begin
      @(posedge clk); #2;
      k++;
    end
    chk("done_seen", done_o, 1);
    chk("busy_at_done", busy_o, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("done_count", done_cnt, 1);
    chk("pass", pass_o, pass);
    chk("err_cnt", err_cnt_o, err);
    chk("first_err_addr", first_err_addr_o, fa);
    chk("first_err_link", first_err_link_o, fl);
    chk("wr_left", exp_wa.size(), 0);
    chk("rd_left", exp_ra.size(), 0);
  endtask

  // Memory/link model: decides grant and read response for the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      gnt_i = 1'b0; rvalid_i = 1'b0; prev_pend = 1'b0;
    end else begin
      if (prev_pend && train_done_i[link_sel_o]) begin
        chk("hold_req", req_o, 1);
        chk("hold_we", we_o, prev_we);
        chk("hold_addr", addr_o, prev_addr);
        if (prev_we) chk("hold_wdata", wdata_o, prev_wd);
      end
      if (drop_arm) begin
        train_done_i[0] = 1'b0; hold0 = 1'b1; drop_arm = 1'b0;
      end
      gnt_i = (hold0 && !link_sel_o) ? 1'b0 : gnt_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid_i = 1'b0; rdata_i = '0;
      if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
        void'(rsp_due.pop_front());
        rvalid_i = 1'b1; rdata_i = rsp_dat.pop_front(); os_model--;
      end else if (spur_req && os_model == 0) begin
        rvalid_i = 1'b1; rdata_i = 64'hdead_beef; spur_req = 1'b0;
      end
      if (done_o) done_cnt++;
      if (busy_o && link_sel_o && !train_done_i[1]) chk("gate_req", req_o, 0);
      if (req_o && gnt_i) begin
        if (we_o) begin
          wr_fires++;
          if (exp_wa.size() != 0) begin
            chk("wr_addr", addr_o, exp_wa.pop_front());
            chk("wr_data", wdata_o, exp_wd.pop_front());
          end else chk("wr_extra", 1, 0);
          mem[addr_o] = wdata_o;
        end else begin
          rd_fires++; os_model++;
          if (os_model > os_peak) os_peak = os_model;
          chk("os_limit", os_model <= 2, 1);
          if (exp_ra.size() != 0) chk("rd_addr", addr_o, exp_ra.pop_front());
          else chk("rd_extra", 1, 0);
          rd_d = mem.exists(addr_o) ? mem[addr_o] : 64'd0;
          if (corrupt_en && addr_o == corrupt_addr && !link_sel_o) rd_d[0] = ~rd_d[0];
          rsp_due.push_back(cyc + lat);
          rsp_dat.push_back(rd_d);
          if (drop_at != 0 && rd_fires == drop_at) drop_arm = 1'b1;
        end
      end
      prev_pend = req_o && !gnt_i; prev_we = we_o; prev_addr = addr_o; prev_wd = wdata_o;
    end
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; mode_i = '0; pattern_i = 1'b0; seed_i = '0;
    base_addr_i = '0; num_words_i = '0; train_done_i = 2'b11; gnt_i = 1'b0;
    rvalid_i = 1'b0; rdata_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_addr", addr_o, 0);
    rst_ni = 1'b1;

    // back-to-back incrementing, both links
    push_link(0, Seed, 32'h5, 4, 4); push_link(0, Seed, 32'h5, 4, 4);
    run(2'd0, 1'b0, Seed, 32'h5, 5'd4);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);

    // bit 0 flipped on link 0 read of address 7
    corrupt_en = 1'b1; corrupt_addr = 32'h7;
    push_link(0, Seed, 32'h5, 4, 4); push_link(0, Seed, 32'h5, 4, 4);
    run(2'd0, 1'b0, Seed, 32'h5, 5'd4);
    finish_run(2'b10, 16'd1, 32'h7, 1'b0);
    corrupt_en = 1'b0;

    // read-compare only against the data already in memory
    push_link(0, Seed, 32'h5, 0, 4); push_link(0, Seed, 32'h5, 0, 4);
    run(2'd2, 1'b0, Seed, 32'h5, 5'd4);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);

    // link 1 trains late; spurious response and a start while busy are both ignored
    train_done_i = 2'b01;
    push_link(0, 64'd7, 32'h100, 3, 3); push_link(0, 64'd7, 32'h100, 3, 3);
    run(2'd3, 1'b0, 64'd7, 32'h100, 5'd3);
    spur_req = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    start_i = 1'b1; seed_i = 64'h99; num_words_i = 5'd9;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    chk("link1_waiting", link_sel_o, 1);
    chk("spur_used", spur_req, 0);
    train_done_i = 2'b11;
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);

    // outstanding limit with slow reads, walking one from seed 0
    lat = 6;
    push_link(1, 64'd0, 32'h200, 8, 8); push_link(1, 64'd0, 32'h200, 8, 8);
    run(2'd0, 1'b1, 64'd0, 32'h200, 5'd8);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);
    chk("os_peak", os_peak, 2);

    // random grant stalls
    lat = 2; gnt_mode = 1;
    push_link(0, 64'hffff_ffff_ffff_fffe, 32'h300, 6, 6);
    push_link(0, 64'hffff_ffff_ffff_fffe, 32'h300, 6, 6);
    run(2'd0, 1'b0, 64'hffff_ffff_ffff_fffe, 32'h300, 5'd6);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);
    chk("stall_wr_beats", wr_fires, 12);
    chk("stall_rd_beats", rd_fires, 12);
    gnt_mode = 0; lat = 1;

    // link 0 loses training after two reads are granted
    drop_at = 2;
    push_link(0, 64'h40, 32'h400, 8, 2); push_link(0, 64'h40, 32'h400, 8, 8);
    run(2'd0, 1'b0, 64'h40, 32'h400, 5'd8);
    finish_run(2'b10, 16'd0, 32'd0, 1'b0);
    chk("loss_rd_beats", rd_fires, 10);
    drop_at = 0; hold0 = 1'b0; train_done_i = 2'b11;

    // burst length clamping, write only
    push_link(1, 64'h5, 32'h700, 1, 0); push_link(1, 64'h5, 32'h700, 1, 0);
    run(2'd1, 1'b1, 64'h5, 32'h700, 5'd0);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);
    push_link(1, 64'h5, 32'h800, 16, 0); push_link(1, 64'h5, 32'h800, 16, 0);
    run(2'd1, 1'b1, 64'h5, 32'h800, 5'd20);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);

    // reset in the middle of the write burst
    push_link(0, Seed, 32'h500, 8, 8);
    run(2'd0, 1'b0, Seed, 32'h500, 5'd8);
    for (int k = 0; k < 100 && wr_fires < 3; k++) begin
      @(posedge clk); #2;
    end
    chk("reached_write", wr_fires >= 3, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", req_o, 0);
    chk("mid_rst_we", we_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_pass", pass_o, 0);
    chk("mid_rst_addr", addr_o, 0);
    chk("mid_rst_wdata", wdata_o, 0);
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); rsp_due.delete(); rsp_dat.delete();
    os_model = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_ni = 1'b1;
    push_link(0, Seed, 32'h600, 4, 4); push_link(0, Seed, 32'h600, 4, 4);
    run(2'd0, 1'b0, Seed, 32'h600, 5'd4);
    finish_run(2'b11, 16'd0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
